// File: rtl/carry_ripple_adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
// Holds the default operand width and the sum register reset value.
package carry_ripple_adder_pkg;

    // Default operand/sum width in bits.
    localparam int CRA_WIDTH_DEFAULT = 4;

    // Widest legal WIDTH; sizes the reset constant below.
    localparam int CRA_WIDTH_MAX = 64;

    // Reset value of the sum register, sliced down to WIDTH bits.
    localparam logic [CRA_WIDTH_MAX-1:0] CRA_SUM_RST = '0;

endpackage

// File: rtl/cra_full_adder.sv
// One-bit full adder cell; the ripple chain is built from these.
// Pure combinational, no state.
module cra_full_adder
    import carry_ripple_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    // Propagate term is shared by the sum bit and the carry-out.
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/carry_ripple_adder.sv
// Registered unsigned ripple-carry adder: {Cout,Sum} = A + B + Cin, 1-cycle latency.
// Define CARRY_RIPPLE_ADDER_OVF_EN to add the registered signed-overflow output Ovf.
module carry_ripple_adder
    import carry_ripple_adder_pkg::*;
#(
    parameter int WIDTH = CRA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef CARRY_RIPPLE_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = Cin;

    // One full adder per bit; carry of bit i feeds bit i+1.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        cra_full_adder u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    // Output register: reset clears, valid loads, otherwise hold the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            Sum       <= CRA_SUM_RST[WIDTH-1:0];
            Cout      <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            Sum       <= s;
            Cout      <= c[WIDTH];
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef CARRY_RIPPLE_ADDER_OVF_EN
    // Signed overflow flag, registered with the same reset/hold rules as Cout.
    always_ff @(posedge clk) begin
        if (rst) begin
            Ovf <= 1'b0;
        end else if (in_valid) begin
            Ovf <= c[WIDTH] ^ c[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_carry_ripple_adder.sv
// Self-checking bench for carry_ripple_adder (WIDTH=4).
// Arithmetic reference model plus directed vectors with literal expectations.
module tb_carry_ripple_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         out_valid;
    logic [W-1:0] Sum;
    logic         Cout;
`ifdef CARRY_RIPPLE_ADDER_OVF_EN
    logic         Ovf;
`endif

    int checks = 0;
    int errors = 0;

    carry_ripple_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .Sum       (Sum),
        .Cout      (Cout)
`ifdef CARRY_RIPPLE_ADDER_OVF_EN
        ,
        .Ovf       (Ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the sampled inputs.
    logic [W-1:0] m_sum;
    logic         m_cout;
    logic         m_valid;
    logic         m_ovf;
    bit           started = 1'b0;

    always @(posedge clk) begin
        int full;
        int sv;
        full = int'(A) + int'(B) + int'(Cin);
        sv   = int'($signed(A)) + int'($signed(B)) + int'(Cin);
        if (rst) begin
            m_sum   <= '0;
            m_cout  <= 1'b0;
            m_ovf   <= 1'b0;
            m_valid <= 1'b0;
        end else if (in_valid) begin
            m_sum   <= full[W-1:0];
            m_cout  <= full[W];
            m_ovf   <= (sv > (2**(W-1)) - 1) || (sv < -(2**(W-1)));
            m_valid <= 1'b1;
        end else begin
            m_valid <= 1'b0;
        end
        started <= 1'b1;
    end

    // Every-cycle comparison of DUT against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("model_sum", 64'(Sum), 64'(m_sum));
            chk("model_cout", 64'(Cout), 64'(m_cout));
            chk("model_valid", 64'(out_valid), 64'(m_valid));
`ifdef CARRY_RIPPLE_ADDER_OVF_EN
            chk("model_ovf", 64'(Ovf), 64'(m_ovf));
`endif
        end
    end

    // Apply inputs at a falling edge; return after the next rising edge took them.
    task automatic drive(input logic r, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ci);
        rst      = r;
        in_valid = v;
        A        = a;
        B        = b;
        Cin      = ci;
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic [W-1:0] s,
                              input logic co, input logic v);
        chk({name, "_sum"}, 64'(Sum), 64'(s));
        chk({name, "_cout"}, 64'(Cout), 64'(co));
        chk({name, "_valid"}, 64'(out_valid), 64'(v));
    endtask

    initial begin
        // Reset held with a live all-ones vector on the inputs.
        drive(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1);
        expect_out("rst0", 4'b0000, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1);
        expect_out("rst1", 4'b0000, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        expect_out("zero", 4'b0000, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0);
        expect_out("one_one", 4'b0010, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 4'b1010, 4'b0110, 1'b0);
        expect_out("carry_zero", 4'b0000, 1'b1, 1'b1);

        drive(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1);
        expect_out("wrap", 4'b1111, 1'b1, 1'b1);
`ifdef CARRY_RIPPLE_ADDER_OVF_EN
        chk("wrap_ovf", 64'(Ovf), 64'(1'b0));
`endif
        drive(1'b0, 1'b1, 4'b0111, 4'b0001, 1'b0);
        expect_out("sgn_ovf", 4'b1000, 1'b0, 1'b1);
`ifdef CARRY_RIPPLE_ADDER_OVF_EN
        chk("sgn_ovf_ovf", 64'(Ovf), 64'(1'b1));
`endif

        // Result must hold while in_valid is low.
        drive(1'b0, 1'b1, 4'b0011, 4'b0100, 1'b0);
        expect_out("pre_hold", 4'b0111, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0);
            expect_out("hold", 4'b0111, 1'b0, 1'b0);
        end
`ifdef CARRY_RIPPLE_ADDER_OVF_EN
        chk("hold_ovf", 64'(Ovf), 64'(1'b0));
`endif

        // Back-to-back adds with a reset pulse on the third.
        drive(1'b0, 1'b1, 4'b0001, 4'b0010, 1'b0);
        expect_out("b2b_1", 4'b0011, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 4'b0101, 4'b0101, 1'b0);
        expect_out("b2b_2", 4'b1010, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 4'b1000, 4'b1000, 1'b0);
        expect_out("b2b_rst", 4'b0000, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'b0110, 4'b0111, 1'b1);
        expect_out("b2b_4", 4'b1110, 1'b0, 1'b1);

        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        expect_out("idle", 4'b1110, 1'b0, 1'b0);

        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
